// File: rtl/mem_bist_pkg.sv
// Shared types, status codes and test-pattern functions for the memory BIST engine.
package mem_bist_pkg;

  typedef enum logic [1:0] {
    PH_WORD,
    PH_HALF,
    PH_BYTE,
    PH_BWWR
  } phase_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH_START,
    ST_WRITE,
    ST_READ,
    ST_PH_PASS,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam logic [15:0] CB_WORD_START = 16'hA040;
  localparam logic [15:0] CB_WORD_PASS  = 16'hAB41;
  localparam logic [15:0] CB_WORD_FAIL  = 16'hAB40;
  localparam logic [15:0] CB_HALF_START = 16'hA020;
  localparam logic [15:0] CB_HALF_PASS  = 16'hAB21;
  localparam logic [15:0] CB_HALF_FAIL  = 16'hAB20;
  localparam logic [15:0] CB_BYTE_START = 16'hA010;
  localparam logic [15:0] CB_BYTE_PASS  = 16'hAB11;
  localparam logic [15:0] CB_BYTE_FAIL  = 16'hAB10;
  localparam logic [15:0] CB_BWWR_START = 16'hA050;
  localparam logic [15:0] CB_BWWR_PASS  = 16'hAB51;
  localparam logic [15:0] CB_BWWR_FAIL  = 16'hAB50;

  function automatic logic [15:0] start_code(input phase_t ph);
    case (ph)
      PH_WORD: return CB_WORD_START;
      PH_HALF: return CB_HALF_START;
      PH_BYTE: return CB_BYTE_START;
      default: return CB_BWWR_START;
    endcase
  endfunction

  function automatic logic [15:0] pass_code(input phase_t ph);
    case (ph)
      PH_WORD: return CB_WORD_PASS;
      PH_HALF: return CB_HALF_PASS;
      PH_BYTE: return CB_BYTE_PASS;
      default: return CB_BWWR_PASS;
    endcase
  endfunction

  function automatic logic [15:0] fail_code(input phase_t ph);
    case (ph)
      PH_WORD: return CB_WORD_FAIL;
      PH_HALF: return CB_HALF_FAIL;
      PH_BYTE: return CB_BYTE_FAIL;
      default: return CB_BWWR_FAIL;
    endcase
  endfunction

  // Byte address of element idx; the byte-write/word-read phase reads whole words.
  function automatic logic [31:0] elem_addr(input logic [31:0] base, input phase_t ph,
                                            input logic rd, input logic [9:0] idx);
    logic [9:0] w;
    case (ph)
      PH_HALF: w = {1'b0, idx[9:1]};
      PH_BYTE: w = {2'b00, idx[9:2]};
      PH_BWWR: w = rd ? idx : {2'b00, idx[9:2]};
      default: w = idx;
    endcase
    return base + {20'd0, w, 2'b00};
  endfunction

  function automatic logic [3:0] lane_strb(input phase_t ph, input logic [9:0] idx);
    case (ph)
      PH_WORD: return 4'hF;
      PH_HALF: return idx[0] ? 4'b1100 : 4'b0011;
      default: return 4'b0001 << idx[1:0];
    endcase
  endfunction

  // Halfword writes carry the sibling element's value in the unselected lane, so a
  // RAM that ignores byte enables still holds a valid halfword image; byte writes
  // leave the other lanes zero so that kind of fault shows up in the byte phase.
  function automatic logic [31:0] write_data(input phase_t ph, input logic [9:0] idx);
    logic [7:0] b;
    case (ph)
      PH_WORD: return {16'hA5A5, 6'd0, idx};
      PH_HALF: return {8'hC3, idx[7:1], 1'b1, 8'hC3, idx[7:1], 1'b0};
      PH_BYTE: b = idx[7:0] ^ 8'h3C;
      default: b = idx[7:0];
    endcase
    return {24'd0, b} << {idx[1:0], 3'b000};
  endfunction

  function automatic logic [31:0] expect_data(input phase_t ph, input logic [9:0] idx);
    if (ph == PH_BWWR)
      return {idx[5:0], 2'b11, idx[5:0], 2'b10, idx[5:0], 2'b01, idx[5:0], 2'b00};
    return write_data(ph, idx);
  endfunction

  function automatic logic [31:0] read_mask(input phase_t ph, input logic [9:0] idx);
    logic [3:0] s;
    if (ph == PH_BWWR)
      return 32'hFFFF_FFFF;
    s = lane_strb(ph, idx);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

endpackage

// File: rtl/mem_bist_bus_if.sv
// Single-transaction valid/ready master with a per-transaction timeout.
module mem_bist_bus_if #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        timeout,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic          valid_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [TW-1:0] wait_cnt;

  // Launch on req when idle (forces a one-cycle gap after each ack), hold until ack or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wait_cnt <= '0;
    end else if (valid_q) begin
      if (mem_ready || (wait_cnt == '0)) begin
        valid_q <= 1'b0;
      end else begin
        wait_cnt <= wait_cnt - TW'(1);
      end
    end else if (req) begin
      valid_q  <= 1'b1;
      addr_q   <= addr;
      wdata_q  <= wdata;
      wstrb_q  <= wstrb;
      wait_cnt <= TW'(TIMEOUT - 1);
    end
  end

  // Read data is consumed by the sequencer in the same cycle ack is high.
  assign ack       = valid_q & mem_ready;
  assign timeout   = valid_q & ~mem_ready & (wait_cnt == '0);
  assign rdata     = ack ? mem_rdata : 32'd0;
  assign mem_valid = valid_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

endmodule

// File: rtl/mem_bist.sv
// Memory BIST sequencer: four write-then-verify phases, status on checkbits.
//
// state       | meaning
// ST_IDLE     | after reset, waiting for start
// ST_PH_START | one cycle showing the phase start code
// ST_WRITE    | writing all elements of the phase
// ST_READ     | reading back and comparing
// ST_PH_PASS  | holding the phase pass code
// ST_DONE     | all phases passed, start relaunches
// ST_FAIL     | mismatch or timeout frozen, start relaunches
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          NWORDS      = 64,
  parameter int          HOLD_CYCLES = 16,
  parameter int          TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic [15:0] checkbits,
  output logic        busy,
  output logic        done,
  output logic        pass
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [9:0] LAST_1N = 10'(NWORDS - 1);
  localparam logic [9:0] LAST_2N = 10'(2 * NWORDS - 1);
  localparam logic [9:0] LAST_4N = 10'(4 * NWORDS - 1);

  state_t        state, state_nxt;
  phase_t        phase, phase_nxt;
  logic [9:0]    idx, idx_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;

  logic          req;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          ack;
  logic          timeout;
  logic [31:0]   rdata;
  logic          mismatch;
  logic [9:0]    wr_last;
  logic [9:0]    rd_last;

  mem_bist_bus_if #(.TIMEOUT(TIMEOUT)) u_bus_if (
    .clk       (clk),
    .rst_n     (resetn),
    .req       (req),
    .addr      (addr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .ack       (ack),
    .rdata     (rdata),
    .timeout   (timeout),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  // Sequencer state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      phase    <= PH_WORD;
      idx      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      idx      <= idx_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Element pattern for the current phase/index and the read-back compare.
  always_comb begin
    req      = (state == ST_WRITE) || (state == ST_READ);
    addr     = elem_addr(BASE_ADDR, phase, state == ST_READ, idx);
    wdata    = (state == ST_WRITE) ? write_data(phase, idx) : 32'd0;
    wstrb    = (state == ST_WRITE) ? lane_strb(phase, idx) : 4'd0;
    mismatch = ((rdata ^ expect_data(phase, idx)) & read_mask(phase, idx)) != 32'd0;
    case (phase)
      PH_WORD: begin wr_last = LAST_1N; rd_last = LAST_1N; end
      PH_HALF: begin wr_last = LAST_2N; rd_last = LAST_2N; end
      PH_BYTE: begin wr_last = LAST_4N; rd_last = LAST_4N; end
      default: begin wr_last = LAST_4N; rd_last = LAST_1N; end
    endcase
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    idx_nxt   = idx;
    hold_nxt  = hold_cnt;
    checkbits = 16'h0000;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (state == ST_DONE) begin
          checkbits = pass_code(phase);
          done      = 1'b1;
          pass      = 1'b1;
        end else if (state == ST_FAIL) begin
          checkbits = fail_code(phase);
          done      = 1'b1;
        end
        if (start) begin
          state_nxt = ST_PH_START;
          phase_nxt = PH_WORD;
          idx_nxt   = '0;
        end
      end
      ST_PH_START: begin
        checkbits = start_code(phase);
        busy      = 1'b1;
        state_nxt = ST_WRITE;
        idx_nxt   = '0;
      end
      ST_WRITE: begin
        checkbits = start_code(phase);
        busy      = 1'b1;
        if (timeout) begin
          state_nxt = ST_FAIL;
        end else if (ack) begin
          if (idx == wr_last) begin
            state_nxt = ST_READ;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 10'd1;
          end
        end
      end
      ST_READ: begin
        checkbits = start_code(phase);
        busy      = 1'b1;
        if (timeout) begin
          state_nxt = ST_FAIL;
        end else if (ack) begin
          if (mismatch) begin
            state_nxt = ST_FAIL;
          end else if (idx == rd_last) begin
            state_nxt = ST_PH_PASS;
            idx_nxt   = '0;
            hold_nxt  = HOLD_LOAD;
          end else begin
            idx_nxt = idx + 10'd1;
          end
        end
      end
      ST_PH_PASS: begin
        checkbits = pass_code(phase);
        busy      = 1'b1;
        if (hold_cnt == '0) begin
          idx_nxt = '0;
          if (phase == PH_BWWR) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_PH_START;
            phase_nxt = phase_t'(phase + 2'd1);
          end
        end else begin
          hold_nxt = hold_cnt - HW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bist.sv
// Self-checking bench for mem_bist: RAM model with fault modes, transaction and status checks.
module tb_mem_bist;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int N    = 4;
  localparam int HOLD = 3;
  localparam int TO   = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'd0;
  logic [15:0] checkbits;
  logic        busy, done, pass;

  mem_bist #(.BASE_ADDR(BASE), .NWORDS(N), .HOLD_CYCLES(HOLD), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .checkbits(checkbits), .busy(busy), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } txn_t;

  int          total = 0;
  int          bad = 0;
  txn_t        exp_q[$];
  logic [15:0] seen_q[$];
  logic [15:0] exp_cb[$];
  int          txn_cnt = 0;
  int          mode = 0;      // 0 good, 1 lane 2 stuck, 2 ignores wstrb, 3 never ready
  int          dly_max = 0;
  bit          spurious = 1'b0;
  bit          chk_en = 1'b0;
  logic [31:0] ram [N];
  int          cyc = 0;
  int          first_valid = -1;
  int          ab40_cyc = -1;
  logic [15:0] last_cb = 16'h0;
  int          run_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic void push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    txn_t t;
    t.addr = a; t.data = d; t.strb = s;
    exp_q.push_back(t);
  endfunction

  // Full expected transaction list of one run, straight from the phase rules.
  function automatic void build_exp();
    logic [15:0] v;
    logic [7:0]  b;
    exp_q.delete();
    for (int i = 0; i < N; i++) push(BASE + 4 * i, 32'hA5A5_0000 | i, 4'hF);
    for (int i = 0; i < N; i++) push(BASE + 4 * i, 32'd0, 4'h0);
    for (int j = 0; j < 2 * N; j++) begin
      v = 16'hC300 | (j & 8'hFF);
      push(BASE + 4 * (j / 2), (j % 2) ? {v, 16'h0} : {16'h0, v}, (j % 2) ? 4'b1100 : 4'b0011);
    end
    for (int j = 0; j < 2 * N; j++) push(BASE + 4 * (j / 2), 32'd0, 4'h0);
    for (int k = 0; k < 4 * N; k++) begin
      b = 8'(k & 255) ^ 8'h3C;
      push(BASE + 4 * (k / 4), 32'(b) << (8 * (k % 4)), 4'(1 << (k % 4)));
    end
    for (int k = 0; k < 4 * N; k++) push(BASE + 4 * (k / 4), 32'd0, 4'h0);
    for (int k = 0; k < 4 * N; k++) begin
      b = 8'(k & 255);
      push(BASE + 4 * (k / 4), 32'(b) << (8 * (k % 4)), 4'(1 << (k % 4)));
    end
    for (int i = 0; i < N; i++) push(BASE + 4 * i, 32'd0, 4'h0);
  endfunction

  // RAM model: decides ready/rdata for the coming edge and commits writes.
  int  wcnt = 0;
  int  dly = 0;
  bit  pend = 1'b0;
  always @(negedge clk) begin
    logic [31:0] off;
    if (!resetn) begin
      mem_ready = 1'b0;
      pend = 1'b0;
    end else if (mem_valid && mode != 3) begin
      if (!pend) begin
        pend = 1'b1;
        wcnt = 0;
        dly = (dly_max > 0) ? int'($urandom_range(0, dly_max)) : 0;
      end
      if (wcnt >= dly) begin
        off = (mem_addr - BASE) >> 2;
        if (off < N) begin
          if (mem_wstrb != 4'h0) begin
            for (int b = 0; b < 4; b++)
              if (mode == 2 || mem_wstrb[b]) ram[off][8*b +: 8] = mem_wdata[8*b +: 8];
          end else begin
            mem_rdata = ram[off];
            if (mode == 1) mem_rdata[23:16] = 8'h00;
          end
        end
        mem_ready = 1'b1;
        pend = 1'b0;
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ready = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
      pend = 1'b0;
    end
  end

  // Per-cycle compare: handshake rules, expected transactions, checkbits trace.
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_strb;
  bit          p_wait = 1'b0;
  bit          p_hs = 1'b0;
  always @(negedge clk) begin
    txn_t t;
    #1;
    cyc++;
    if (!resetn || !chk_en) begin
      p_wait = 1'b0;
      p_hs = 1'b0;
    end else begin
      if (done && !pass) begin
        check("fail_bus_quiet", 32'(mem_valid), 32'd0);
      end else if (p_wait) begin
        check("hold_valid", 32'(mem_valid), 32'd1);
        check("hold_addr", mem_addr, p_addr);
        check("hold_wdata", mem_wdata, p_wdata);
        check("hold_wstrb", 32'(mem_wstrb), 32'(p_strb));
      end
      if (p_hs) check("gap_valid", 32'(mem_valid), 32'd0);
      if (mem_valid && first_valid < 0) first_valid = cyc;
      if (mem_valid && mem_ready) begin
        txn_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_txn", 32'(txn_cnt), 32'd0);
        end else begin
          t = exp_q.pop_front();
          check("txn_addr", mem_addr, t.addr);
          check("txn_wstrb", 32'(mem_wstrb), 32'(t.strb));
          check("txn_wdata", mem_wdata & strb_mask(t.strb), t.data & strb_mask(t.strb));
        end
      end
      if (checkbits !== last_cb) begin
        if (last_cb == 16'hAB41 || last_cb == 16'hAB21 || last_cb == 16'hAB11)
          check("pass_hold", 32'(run_len), 32'(HOLD));
        seen_q.push_back(checkbits);
        if (checkbits == 16'hAB40 && ab40_cyc < 0) ab40_cyc = cyc;
        last_cb = checkbits;
        run_len = 1;
      end else begin
        run_len++;
      end
      p_wait  = mem_valid && !mem_ready;
      p_hs    = mem_valid && mem_ready;
      p_addr  = mem_addr;
      p_wdata = mem_wdata;
      p_strb  = mem_wstrb;
    end
  end

  task automatic prep(input int m, input int dm, input bit sp);
    mode = m;
    dly_max = dm;
    spurious = sp;
    build_exp();
    seen_q.delete();
    txn_cnt = 0;
    last_cb = checkbits;
    run_len = 0;
    first_valid = -1;
    ab40_cyc = -1;
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!(done && !busy) && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check({name, "_finished"}, 32'(done && !busy), 32'd1);
  endtask

  task automatic check_seq(input string name);
    check({name, "_seq_len"}, 32'(seen_q.size()), 32'(exp_cb.size()));
    for (int i = 0; i < exp_cb.size(); i++)
      check({name, "_seq"}, (i < seen_q.size()) ? 32'(seen_q[i]) : 32'hFFFF_FFFF, 32'(exp_cb[i]));
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_valid"}, 32'(mem_valid), 32'd0);
    check({name, "_flags"}, {29'd0, busy, done, pass}, 32'd0);
    check({name, "_checkbits"}, 32'(checkbits), 32'd0);
    check({name, "_addr"}, mem_addr, 32'd0);
    check({name, "_wstrb"}, 32'(mem_wstrb), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) ram[i] = 32'hDEAD_0000 | i;
    #3;
    check_idle_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Pin the expected-transaction model with hand-computed entries.
    build_exp();
    check("model_size", 32'(exp_q.size()), 32'd76);
    check("model_w0_addr", exp_q[0].addr, 32'h0000_0100);
    check("model_w0_data", exp_q[0].data, 32'hA5A5_0000);
    check("model_h3_addr", exp_q[11].addr, 32'h0000_0104);
    check("model_h3_data", exp_q[11].data, 32'hC303_0000);
    check("model_h3_strb", 32'(exp_q[11].strb), 32'h0000_000C);
    check("model_b5_data", exp_q[29].data, 32'h0000_3900);
    check("model_b5_strb", 32'(exp_q[29].strb), 32'h0000_0002);
    check("model_last_rd", exp_q[75].addr, 32'h0000_010C);
    chk_en = 1'b1;

    // Zero-wait RAM, plus a start pulse while busy that must be ignored.
    prep(0, 0, 1'b0);
    launch();
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("zero_wait", 3000);
    exp_cb = '{16'hA040, 16'hAB41, 16'hA020, 16'hAB21, 16'hA010, 16'hAB11, 16'hA050, 16'hAB51};
    check_seq("zero_wait");
    check("zero_wait_txns", 32'(txn_cnt), 32'd76);
    check("zero_wait_result", {29'd0, busy, done, pass}, 32'd3);
    check("zero_wait_code", 32'(checkbits), 32'h0000_AB51);

    // Random ready delay with stray ready pulses while idle.
    prep(0, 5, 1'b1);
    launch();
    wait_done("rand_wait", 5000);
    check_seq("rand_wait");
    check("rand_wait_txns", 32'(txn_cnt), 32'd76);
    check("rand_wait_result", {29'd0, busy, done, pass}, 32'd3);

    // Byte lane 2 stuck at zero: first phase-0 read fails.
    prep(1, 0, 1'b0);
    launch();
    wait_done("lane2", 3000);
    repeat (20) @(negedge clk);
    exp_cb = '{16'hA040, 16'hAB40};
    check_seq("lane2");
    check("lane2_txns", 32'(txn_cnt), 32'd5);
    check("lane2_result", {29'd0, busy, done, pass}, 32'd2);

    // RAM ignoring write strobes: word and halfword pass, byte fails on first read.
    prep(2, 0, 1'b0);
    launch();
    wait_done("nostrb", 3000);
    repeat (10) @(negedge clk);
    exp_cb = '{16'hA040, 16'hAB41, 16'hA020, 16'hAB21, 16'hA010, 16'hAB10};
    check_seq("nostrb");
    check("nostrb_txns", 32'(txn_cnt), 32'd41);
    check("nostrb_result", {29'd0, busy, done, pass}, 32'd2);

    // Ready never arrives: fail code exactly TIMEOUT cycles after first valid.
    prep(3, 0, 1'b0);
    launch();
    wait_done("timeout", 500);
    repeat (5) @(negedge clk);
    exp_cb = '{16'hA040, 16'hAB40};
    check_seq("timeout");
    check("timeout_latency", 32'(ab40_cyc - first_valid), 32'(TO));
    check("timeout_txns", 32'(txn_cnt), 32'd0);
    check("timeout_result", {29'd0, busy, done, pass}, 32'd2);

    // Reset in the middle of a phase-1 write, then a clean full run.
    prep(0, 2, 1'b0);
    launch();
    begin
      int n = 0;
      while (!(checkbits == 16'hA020 && mem_valid && mem_wstrb != 4'h0) && n < 1000) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("rst_reached_phase1", 32'(checkbits == 16'hA020 && mem_valid), 32'd1);
    end
    #2;
    chk_en = 1'b0;
    resetn = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    chk_en = 1'b1;
    prep(0, 0, 1'b0);
    launch();
    wait_done("after_rst", 3000);
    exp_cb = '{16'hA040, 16'hAB41, 16'hA020, 16'hAB21, 16'hA010, 16'hAB11, 16'hA050, 16'hAB51};
    check_seq("after_rst");
    check("after_rst_txns", 32'(txn_cnt), 32'd76);
    check("after_rst_result", {29'd0, busy, done, pass}, 32'd3);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
